uart_rx_monitor: RTL and testbench

- Synthesizable 8N1 UART receiver for the bench side of the SoC's serial port, observing the chip's UART TX pin (mprj_io[6]).
- Deserializes characters and presents each byte with a one-cycle strobe.
- Flags framing errors and counts received bytes so benches and self-checking logic can log firmware progress messages.

---
 rtl/uart_rx_monitor.sv | 127 ++++++++++++
 tb/tb_uart_rx_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - 8N1 UART receiver monitor with framing-error flag and good-byte counter
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 347,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clock,
    input  logic        rstb,
    input  logic        ser_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] rx_count
);
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [TW-1:0]          timer, timer_next;
    logic                   timer_done;
    logic [2:0]             bit_idx, bit_idx_next;
    logic [7:0]             shift, shift_next, rx_data_next;
    logic                   rx_valid_next, frame_err_next, busy_next;
    logic [15:0]            rx_count_next;

    assign s          = sync[SYNC_STAGES-1];
    assign timer_done = (timer == '0);

    // Idle-high preset keeps reset release from looking like a start bit
    always_ff @(posedge clock or negedge rstb) begin
        if (!rstb) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ser_rx};
        end
    end

    always_ff @(posedge clock or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            rx_count  <= '0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            rx_data   <= rx_data_next;
            rx_valid  <= rx_valid_next;
            frame_err <= frame_err_next;
            busy      <= busy_next;
            rx_count  <= rx_count_next;
        end
    end

    always_comb begin
        state_next     = state;
        timer_next     = timer_done ? timer : timer - 1'b1;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        rx_data_next   = rx_data;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        rx_count_next  = rx_count;
        case (state)
            IDLE: begin
                if (!s) begin
                    state_next = START;
                    timer_next = HALF_LOAD;
                end
            end
            START: begin
                if (timer_done) begin
                    if (s) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                        timer_next   = FULL_LOAD;
                    end
                end
            end
            DATA: begin
                if (timer_done) begin
                    shift_next[bit_idx] = s;
                    bit_idx_next        = bit_idx + 3'd1;
                    timer_next          = FULL_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (timer_done) begin
                    rx_data_next = shift;
                    if (s) begin
                        rx_valid_next = 1'b1;
                        rx_count_next = rx_count + 16'd1;
                        state_next    = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line is a break, not a run of start bits
                if (s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end
endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - directed self-checking bench for uart_rx_monitor
module tb_uart_rx_monitor;
    logic        clock = 1'b0;
    logic        rstb  = 1'b0;
    logic        ser_a = 1'b1;
    logic        ser_b = 1'b1;
    logic [7:0]  rx_data_a, rx_data_b;
    logic        rx_valid_a, rx_valid_b, frame_err_a, frame_err_b, busy_a, busy_b;
    logic [15:0] rx_count_a, rx_count_b;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    int ferr_a = 0;
    int ferr_b = 0;
    int viol = 0;
    logic busy_seen = 1'b0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int got_t[$];
    int starts[$];

    uart_rx_monitor #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut_a (
        .clock(clock), .rstb(rstb), .ser_rx(ser_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .frame_err(frame_err_a), .busy(busy_a), .rx_count(rx_count_a)
    );

    uart_rx_monitor #(.CLKS_PER_BIT(347), .SYNC_STAGES(2)) dut_b (
        .clock(clock), .rstb(rstb), .ser_rx(ser_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .frame_err(frame_err_b), .busy(busy_b), .rx_count(rx_count_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (rx_valid_a) begin
            got_a.push_back(rx_data_a);
            got_t.push_back(cyc);
        end
        if (rx_valid_b) got_b.push_back(rx_data_b);
        if (frame_err_a) ferr_a++;
        if (frame_err_b) ferr_b++;
        if (busy_a) busy_seen = 1'b1;
        if ((rx_valid_a && frame_err_a) || ((rx_valid_a || frame_err_a) && prev_a)) viol++;
        if ((rx_valid_b && frame_err_b) || ((rx_valid_b || frame_err_b) && prev_b)) viol++;
        prev_a = rx_valid_a | frame_err_a;
        prev_b = rx_valid_b | frame_err_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i < got_a.size()) ? {24'd0, got_a[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qb(input int i);
        return (i < got_b.size()) ? {24'd0, got_b[i]} : 32'hFFFF_FFFF;
    endfunction

    // Edges from the first clock that sees the line low to the rx_valid edge
    task automatic check_lat(input string tag, input int i);
        int lat;
        lat = (i < got_t.size() && i < starts.size()) ? got_t[i] - starts[i] - 1 : -1;
        nchk++;
        assert ((lat >= 153 && lat <= 155) === 1'b1) else begin
            nfail++;
            $error("FAIL %s: observed latency=%0d expected=154 +/-1", tag, lat);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) ser_a = v;
        else ser_b = v;
    endtask

    // Caller is aligned to a falling edge; each bit is held for per rising edges
    task automatic send(input int which, input logic [7:0] b, input int per, input logic stop_v);
        if (which == 0) starts.push_back(cyc);
        set_line(which, 1'b0);
        repeat (per) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            set_line(which, b[i]);
            repeat (per) @(negedge clock);
        end
        set_line(which, stop_v);
        repeat (per) @(negedge clock);
        set_line(which, 1'b1);
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        repeat (2) @(negedge clock);
        got_a.delete();
        got_b.delete();
        got_t.delete();
        starts.delete();
        ferr_a = 0;
        ferr_b = 0;
        busy_seen = 1'b0;
        rstb = 1'b1;
        repeat (20) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_rx_data", rx_data_a, 8'h00);
        check("rst_rx_valid", rx_valid_a, 1'b0);
        check("rst_frame_err", frame_err_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_rx_count", rx_count_a, 16'h0000);
        do_reset();

        send(0, 8'h41, 16, 1'b1);
        repeat (20) @(negedge clock);
        check("a_nvalid", got_a.size(), 1);
        check("a_data", qa(0), 8'h41);
        check("a_count", rx_count_a, 16'd1);
        check("a_ferr", ferr_a, 0);
        check("a_busy_after", busy_a, 1'b0);

        // Glitch on an idle line: 6 clocks low is under half a bit
        @(negedge clock);
        busy_seen = 1'b0;
        ser_a = 1'b0;
        repeat (6) @(negedge clock);
        ser_a = 1'b1;
        repeat (40) @(negedge clock);
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_nvalid", got_a.size(), 1);
        check("glitch_ferr", ferr_a, 0);
        check("glitch_count", rx_count_a, 16'd1);

        do_reset();
        send(0, 8'hAB, 16, 1'b1);
        send(0, 8'h40, 16, 1'b1);
        send(0, 8'h0A, 16, 1'b1);
        repeat (40) @(negedge clock);
        check("b2b_nvalid", got_a.size(), 3);
        check("b2b_data0", qa(0), 8'hAB);
        check("b2b_data1", qa(1), 8'h40);
        check("b2b_data2", qa(2), 8'h0A);
        check("b2b_count", rx_count_a, 16'd3);
        check_lat("b2b_lat0", 0);
        check_lat("b2b_lat1", 1);
        check_lat("b2b_lat2", 2);

        do_reset();
        send(0, 8'h55, 16, 1'b0);
        ser_a = 1'b0;
        repeat (80) @(negedge clock);
        ser_a = 1'b1;
        repeat (20) @(negedge clock);
        check("fe_ferr", ferr_a, 1);
        check("fe_nvalid_first", got_a.size(), 0);
        check("fe_busy_idle", busy_a, 1'b0);
        send(0, 8'h3E, 16, 1'b1);
        repeat (40) @(negedge clock);
        check("fe_nvalid", got_a.size(), 1);
        check("fe_data", qa(0), 8'h3E);
        check("fe_count", rx_count_a, 16'd1);
        check("fe_ferr_total", ferr_a, 1);

        // Abort 0x5A at data bit 4 with reset
        do_reset();
        ser_a = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            ser_a = (i % 2 == 1);
            repeat (16) @(negedge clock);
        end
        ser_a = 1'b1;
        repeat (8) @(negedge clock);
        check("abort_busy_pre", busy_a, 1'b1);
        rstb = 1'b0;
        #1;
        check("abort_busy", busy_a, 1'b0);
        check("abort_count", rx_count_a, 16'd0);
        do_reset();
        send(0, 8'h44, 16, 1'b1);
        repeat (40) @(negedge clock);
        check("abort_nvalid", got_a.size(), 1);
        check("abort_data", qa(0), 8'h44);
        check("abort_count_after", rx_count_a, 16'd1);

        force dut_a.rx_count = 16'hFFFF;
        @(posedge clock);
        #1;
        release dut_a.rx_count;
        @(negedge clock);
        check("wrap_preload", rx_count_a, 16'hFFFF);
        send(0, 8'h21, 16, 1'b1);
        repeat (40) @(negedge clock);
        check("wrap_count", rx_count_a, 16'h0000);
        check("wrap_data", rx_data_a, 8'h21);

        // +/-3% transmitter rate against 347 clocks per bit
        do_reset();
        repeat (400) @(negedge clock);
        send(1, 8'h00, 357, 1'b1);
        send(1, 8'hFF, 357, 1'b1);
        send(1, 8'h00, 337, 1'b1);
        send(1, 8'hFF, 337, 1'b1);
        repeat (400) @(negedge clock);
        check("tol_nvalid", got_b.size(), 4);
        check("tol_data0", qb(0), 8'h00);
        check("tol_data1", qb(1), 8'hFF);
        check("tol_data2", qb(2), 8'h00);
        check("tol_data3", qb(3), 8'hFF);
        check("tol_count", rx_count_b, 16'd4);
        check("tol_ferr", ferr_b, 0);
        check("strobe_exclusive", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
